serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl_pkg.sv | 20 ++
 rtl/serial_add_ctrl_if.sv | 16 +
 rtl/serial_add_ctrl_fa.sv | 11 +
 rtl/serial_add_ctrl.sv | 85 ++++++++
 tb/tb_serial_add_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder sequencer.
package serial_add_ctrl_pkg;

    localparam int unsigned ST_W    = 2;
    localparam logic [1:0]  ST_IDLE_ENC = 2'd0;
    localparam logic [1:0]  ST_RUN_ENC  = 2'd1;
    localparam logic [1:0]  ST_DONE_ENC = 2'd2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_RUN  = ST_RUN_ENC,
        ST_DONE = ST_DONE_ENC
    } state_t;

    // An operation is in flight from the accepting edge until the DONE cycle ends.
    function automatic logic is_busy(input state_t s);
        return (s == ST_RUN) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Start/busy/done request bus with operands and result for serial_add_ctrl.
interface serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             co;

    modport master (output start, a, b, cin, input  busy, done, sum, co);
    modport slave  (input  start, a, b, cin, output busy, done, sum, co);
endinterface

// File: rtl/serial_add_ctrl_fa.sv
// Existing 1-bit full adder reused as the serial datapath.
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic co
);
    assign sum = a ^ b ^ cin;
    assign co  = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: {co,sum} = a + b + cin, one bit per clock
// through a single full adder, LSB first.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_add_ctrl_if.slave  bus
);

    localparam int unsigned CNT_W = (WIDTH < 2) ? 1 : $clog2(WIDTH);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_s_sh;
    logic               r_c;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_co;

    logic               w_fa_sum;
    logic               w_fa_co;

    fa u_fa (
        .a   (r_a_sh[0]),
        .b   (r_b_sh[0]),
        .cin (r_c),
        .sum (w_fa_sum),
        .co  (w_fa_co)
    );

    // Sequencer and datapath registers; sum/co only change on the final RUN edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_s_sh  <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_co    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_a_sh  <= bus.a;
                        r_b_sh  <= bus.b;
                        r_c     <= bus.cin;
                        r_s_sh  <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_s_sh <= {w_fa_sum, r_s_sh[WIDTH-1:1]};
                    r_a_sh <= r_a_sh >> 1;
                    r_b_sh <= r_b_sh >> 1;
                    r_c    <= w_fa_co;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_sum   <= {w_fa_sum, r_s_sh[WIDTH-1:1]};
                        r_co    <= w_fa_co;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = is_busy(r_state);
    assign bus.done = (r_state == ST_DONE);
    assign bus.sum  = r_sum;
    assign bus.co   = r_co;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=4 (full coverage) and WIDTH=8.
module tb_serial_add_ctrl;

    localparam int unsigned W4 = 4;
    localparam int unsigned W8 = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(W4)) bus4 ();
    serial_add_ctrl_if #(.WIDTH(W8)) bus8 ();

    serial_add_ctrl #(.WIDTH(W4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    serial_add_ctrl #(.WIDTH(W8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W4:0] q4[$];
    logic [W8:0] q8[$];
    logic [W4:0] held4 = '0;
    logic [W4:0] e4;
    logic [W8:0] e8;
    int unsigned acc4 = 0;
    int unsigned ready4 = 0;
    bit          have4 = 1'b0;
    bit          mon_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference timing: busy from the accept edge through DONE, done exactly WIDTH edges later.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mon_en) begin
            chk("busy4", 64'(bus4.busy), 64'(have4 && (cyc <= acc4 + W4)));
            chk("done4", 64'(bus4.done), 64'(have4 && (cyc == acc4 + W4)));
            if (bus4.done === 1'b1) begin
                if (q4.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL done4_unexpected: got done with empty queue (cyc %0d)", cyc);
                end else begin
                    e4 = q4.pop_front();
                    chk("result4", 64'({bus4.co, bus4.sum}), 64'(e4));
                    held4 = e4;
                end
            end else begin
                chk("hold4", 64'({bus4.co, bus4.sum}), 64'(held4));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && mon_en && bus8.done === 1'b1) begin
            if (q8.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL done8_unexpected: got done with empty queue (cyc %0d)", cyc);
            end else begin
                e8 = q8.pop_front();
                chk("result8", 64'({bus8.co, bus8.sum}), 64'(e8));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic c, input bit hold);
        while (cyc + 1 < ready4) begin
            bus4.a   = 4'($urandom);
            bus4.b   = 4'($urandom);
            bus4.cin = 1'($urandom);
            @(negedge clk);
        end
        bus4.start = 1'b1;
        bus4.a     = a;
        bus4.b     = b;
        bus4.cin   = c;
        @(posedge clk);
        #1;
        q4.push_back(5'(a) + 5'(b) + 5'(c));
        acc4   = cyc;
        have4  = 1'b1;
        ready4 = cyc + W4 + 2;
        if (!hold) bus4.start = 1'b0;
        bus4.a   = 4'($urandom);
        bus4.b   = 4'($urandom);
        bus4.cin = 1'($urandom);
        @(negedge clk);
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c);
        bus8.start = 1'b1;
        bus8.a     = a;
        bus8.b     = b;
        bus8.cin   = c;
        @(posedge clk);
        #1;
        q8.push_back(9'(a) + 9'(b) + 9'(c));
        bus8.start = 1'b0;
        bus8.a     = 8'($urandom);
        bus8.b     = 8'($urandom);
        bus8.cin   = 1'($urandom);
        repeat (W8 + 2) @(negedge clk);
    endtask

    int perm[512];
    int tmp;
    int j;
    bit h;

    initial begin
        rst_n      = 1'b0;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
        #1;
        chk("rst_busy4", 64'(bus4.busy), 64'(0));
        chk("rst_done4", 64'(bus4.done), 64'(0));
        chk("rst_res4",  64'({bus4.co, bus4.sum}), 64'(0));
        chk("rst_res8",  64'({bus8.co, bus8.sum, bus8.busy, bus8.done}), 64'(0));
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        issue4(4'd7, 4'd8, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        issue4(4'd7, 4'd8, 1'b1, 1'b0);

        // Held start: back-to-back operations WIDTH+2 cycles apart.
        issue4(4'd15, 4'd1, 1'b0, 1'b1);
        issue4(4'd3,  4'd4, 1'b0, 1'b0);

        // A start pulse two cycles into RUN must be ignored.
        issue4(4'd5, 4'd6, 1'b1, 1'b0);
        @(negedge clk);
        bus4.start = 1'b1; bus4.a = 4'd1; bus4.b = 4'd1; bus4.cin = 1'b0;
        @(negedge clk);
        bus4.start = 1'b0;
        repeat (6) @(negedge clk);

        // Asynchronous reset after two bits have been shifted.
        issue4(4'd9, 4'd5, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy4", 64'(bus4.busy), 64'(0));
        chk("midrst_done4", 64'(bus4.done), 64'(0));
        chk("midrst_sum4",  64'(bus4.sum),  64'(0));
        chk("midrst_co4",   64'(bus4.co),   64'(0));
        q4.delete();
        have4  = 1'b0;
        held4  = '0;
        ready4 = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (7) @(negedge clk);
        issue4(4'd12, 4'd6, 1'b0, 1'b0);

        // Every a, b, cin combination in random order with random start patterns.
        for (int i = 0; i < 512; i++) perm[i] = i;
        for (int i = 511; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        for (int k = 0; k < 512; k++) begin
            h = (k == 511) ? 1'b0 : 1'($urandom_range(0, 1));
            issue4(4'(perm[k] >> 5), 4'(perm[k] >> 1), 1'(perm[k]), h);
            if (!h) repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        for (int i = 0; i < 50 && q4.size() != 0; i++) @(negedge clk);
        if (q4.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain4: %0d results pending, required 0", q4.size());
        end

        issue8(8'd255, 8'd255, 1'b1);
        for (int k = 0; k < 20; k++) issue8(8'($urandom), 8'($urandom), 1'($urandom));
        for (int i = 0; i < 50 && q8.size() != 0; i++) @(negedge clk);
        if (q8.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain8: %0d results pending, required 0", q8.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
